spi_mem_master: RTL

//  Parametrised successor SPI master for the manquehuito SoC external memory link.
//  - Runs 23LC-style SRAM transactions: 8-bit opcode, ADDR_W-bit address, then a burst of 1..MAX_BYTES data bytes.
//  - Drives NUM_CS independent chip selects (e.g. instruction and data memory) and supports SPI mode 0 or mode 3.
//  - Sits between the control unit and the SPI pins, in place of the fixed 2-byte, single-CS master.

---
 rtl/spi_pkg.sv | 19 +
 rtl/spi_clk_gen.sv | 29 ++
 rtl/spi_mem_master.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared opcodes, FSM encoding and opcode helper for the external SRAM SPI master.
package spi_pkg;

  localparam logic [7:0] SPI_CMD_READ  = 8'h03;
  localparam logic [7:0] SPI_CMD_WRITE = 8'h02;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    DONE  = 3'd4
  } spi_state_e;

  function automatic logic [7:0] spi_opcode(input logic rnw);
    return rnw ? SPI_CMD_READ : SPI_CMD_WRITE;
  endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// Half-period timer: pulses tick for one core cycle every H cycles while en is high.
module spi_clk_gen #(
  parameter int H = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam int CW = (H > 1) ? $clog2(H) : 1;
  localparam logic [CW-1:0] LAST = CW'(H - 1);

  logic [CW-1:0] cnt_r;

  assign tick = en && (cnt_r == LAST);

  // Half-period counter, held at zero whenever the generator is disabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (!en || tick) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + CW'(1);
    end
  end

endmodule

// File: rtl/spi_mem_master.sv
// SPI master for 23LC-style SRAM: opcode, address and a 1..MAX_BYTES data burst on one of NUM_CS selects.
module spi_mem_master
  import spi_pkg::*;
#(
  parameter int CLK_DIV   = 4,
  parameter int ADDR_W    = 16,
  parameter int MAX_BYTES = 4,
  parameter int NUM_CS    = 2,
  parameter int CPOL      = 0,
  localparam int CSW      = (NUM_CS > 1) ? $clog2(NUM_CS) : 1,
  localparam int NBW      = $clog2(MAX_BYTES + 1)
) (
  input  logic                   clk_core_i,
  input  logic                   rst_n_i,
  input  logic                   start_i,
  input  logic [CSW-1:0]         cs_sel_i,
  input  logic [ADDR_W-1:0]      addr_i,
  input  logic                   rnw_i,
  input  logic [NBW-1:0]         nbytes_i,
  input  logic [8*MAX_BYTES-1:0] wdata_i,
  output logic [8*MAX_BYTES-1:0] rdata_o,
  output logic                   done_o,
  output logic                   err_o,
  output logic                   busy_o,
  output logic                   spi_sclk_o,
  output logic                   spi_mosi_o,
  input  logic                   spi_miso_i,
  output logic [NUM_CS-1:0]      spi_cs_no
);

  localparam int H         = CLK_DIV / 2;
  localparam int HDR       = 8 + ADDR_W;
  localparam int TX_W      = HDR + 8 * MAX_BYTES;
  localparam int BCW       = $clog2(TX_W + 1);
  localparam int RXIW      = $clog2(8 * MAX_BYTES);
  localparam logic IDLE_SCLK = 1'(CPOL);

  spi_state_e state_r, next_state_s;

  logic                   tick_s, clk_en_s;
  logic                   reject_s, accept_s, last_bit_s, in_data_s;
  logic [TX_W-1:0]        tx_r, tx_load_s;
  logic [BCW-1:0]         bit_cnt_r, n_bits_r, n_bits_s;
  logic [RXIW-1:0]        rx_idx_s;
  logic                   phase_r, rnw_r;
  logic [8*MAX_BYTES-1:0] rx_buf_r, rdata_r;
  logic [NUM_CS-1:0]      sel_mask_s, cs_n_r, cs_n_s;
  logic                   done_r, done_s, err_r, err_s, busy_r, busy_s;
  logic                   sclk_r, sclk_s, mosi_r, mosi_s;

  assign clk_en_s = (state_r == SETUP) || (state_r == SHIFT) || (state_r == HOLD);

  spi_clk_gen #(.H(H)) u_clk_gen (
    .clk   (clk_core_i),
    .rst_n (rst_n_i),
    .en    (clk_en_s),
    .tick  (tick_s)
  );

  // Request decode and frame image built from the live request inputs
  always_comb begin
    reject_s  = (nbytes_i == '0) || (nbytes_i > NBW'(MAX_BYTES)) || (int'(cs_sel_i) >= NUM_CS);
    accept_s  = (state_r == IDLE) && start_i && !reject_s;
    n_bits_s  = BCW'(HDR) + BCW'({nbytes_i, 3'b000});
    tx_load_s = '0;
    tx_load_s[TX_W-1 -: 8]      = spi_opcode(rnw_i);
    tx_load_s[TX_W-9 -: ADDR_W] = addr_i;
    for (int k = 0; k < MAX_BYTES; k++) begin
      if (!rnw_i) begin
        tx_load_s[8*(MAX_BYTES-1-k) +: 8] = wdata_i[8*k +: 8];
      end else begin
        tx_load_s[8*(MAX_BYTES-1-k) +: 8] = 8'h00;
      end
    end
    for (int i = 0; i < NUM_CS; i++) begin
      sel_mask_s[i] = (int'(cs_sel_i) != i);
    end
    last_bit_s = (bit_cnt_r == (n_bits_r - BCW'(1)));
    in_data_s  = (bit_cnt_r >= BCW'(HDR));
    // Data bit d lands in byte d/8, MSB first, so the in-byte position is inverted
    rx_idx_s   = RXIW'(bit_cnt_r - BCW'(HDR)) ^ RXIW'(7);
  end

  // Next-state and next pin/handshake values
  always_comb begin
    next_state_s = state_r;
    sclk_s       = sclk_r;
    mosi_s       = mosi_r;
    cs_n_s       = cs_n_r;
    done_s       = 1'b0;
    err_s        = 1'b0;
    busy_s       = busy_r;
    case (state_r)
      IDLE: begin
        busy_s = 1'b0;
        cs_n_s = '1;
        sclk_s = IDLE_SCLK;
        mosi_s = 1'b0;
        if (start_i && reject_s) begin
          done_s = 1'b1;
          err_s  = 1'b1;
        end else if (start_i) begin
          next_state_s = SETUP;
          busy_s       = 1'b1;
          cs_n_s       = sel_mask_s;
          mosi_s       = tx_load_s[TX_W-1];
        end else begin
          next_state_s = IDLE;
        end
      end
      SETUP: begin
        if (tick_s) begin
          next_state_s = SHIFT;
          sclk_s       = 1'b0;
        end else begin
          next_state_s = SETUP;
        end
      end
      SHIFT: begin
        if (tick_s && !phase_r) begin
          sclk_s = 1'b1;
        end else if (tick_s && last_bit_s) begin
          next_state_s = HOLD;
          sclk_s       = IDLE_SCLK;
          mosi_s       = 1'b0;
        end else if (tick_s) begin
          sclk_s = 1'b0;
          mosi_s = tx_r[TX_W-2];
        end else begin
          next_state_s = SHIFT;
        end
      end
      HOLD: begin
        if (tick_s) begin
          next_state_s = DONE;
          cs_n_s       = '1;
          done_s       = 1'b1;
        end else begin
          next_state_s = HOLD;
        end
      end
      DONE: begin
        next_state_s = IDLE;
        busy_s       = 1'b0;
      end
      default: begin
        next_state_s = IDLE;
        busy_s       = 1'b0;
        cs_n_s       = '1;
        sclk_s       = IDLE_SCLK;
        mosi_s       = 1'b0;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk_core_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Registered pins and handshake
  always_ff @(posedge clk_core_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sclk_r <= IDLE_SCLK;
      mosi_r <= 1'b0;
      cs_n_r <= '1;
      done_r <= 1'b0;
      err_r  <= 1'b0;
      busy_r <= 1'b0;
    end else begin
      sclk_r <= sclk_s;
      mosi_r <= mosi_s;
      cs_n_r <= cs_n_s;
      done_r <= done_s;
      err_r  <= err_s;
      busy_r <= busy_s;
    end
  end

  // Frame datapath: request latch, TX shifter, bit counter, RX buffer
  always_ff @(posedge clk_core_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      tx_r      <= '0;
      n_bits_r  <= '0;
      bit_cnt_r <= '0;
      phase_r   <= 1'b0;
      rnw_r     <= 1'b0;
      rx_buf_r  <= '0;
      rdata_r   <= '0;
    end else if (accept_s) begin
      tx_r      <= tx_load_s;
      n_bits_r  <= n_bits_s;
      bit_cnt_r <= '0;
      phase_r   <= 1'b0;
      rnw_r     <= rnw_i;
      rx_buf_r  <= '0;
    end else if ((state_r == SHIFT) && tick_s) begin
      if (!phase_r) begin
        phase_r <= 1'b1;
        if (rnw_r && in_data_s) begin
          rx_buf_r[rx_idx_s] <= spi_miso_i;
        end
      end else begin
        phase_r   <= 1'b0;
        bit_cnt_r <= bit_cnt_r + BCW'(1);
        tx_r      <= {tx_r[TX_W-2:0], 1'b0};
      end
    end else if ((state_r == HOLD) && tick_s && rnw_r) begin
      rdata_r <= rx_buf_r;
    end
  end

  assign rdata_o    = rdata_r;
  assign done_o     = done_r;
  assign err_o      = err_r;
  assign busy_o     = busy_r;
  assign spi_sclk_o = sclk_r;
  assign spi_mosi_o = mosi_r;
  assign spi_cs_no  = cs_n_r;

endmodule
